alu_issue_ctrl: RTL

Sequential front end for the gate-level 4-bit ALU datapath. It accepts an operand/opcode transaction over a valid/ready handshake and registers the operands and the 2-bit operation select that drive the ALU's 4:1 result-select muxes. It waits a fixed number of settle cycles for the combinational path, then captures the result, carry and zero flag into an output register offered downstream over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequential front end for the gate-level ALU datapath. It accepts one
// operand/opcode transaction over a valid/ready handshake and registers the
// operands and the 2-bit result-mux select. It then waits SETTLE_CYCLES clock
// cycles for the combinational ALU path to settle. Finally it captures
// result, carry and a zero flag into an output register. That register is
// offered downstream over a second valid/ready handshake.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid / in_ready       upstream handshake
//   in_a, in_b, in_op         operands and operation select, sampled on accept
//   alu_a, alu_b, alu_select  registered operands/select driving the ALU
//   alu_result, alu_carry     combinational ALU outputs, sampled on capture
//   out_valid / out_ready     downstream handshake
//   out_result, out_carry     captured result and carry/borrow
//   out_zero                  1 when the captured result is zero
//   out_op                    select that produced the captured result
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [1:0]       out_op
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // A zero-cycle settle would capture the ALU output on the same edge that
    // launches its operands, so the counter range is enforced at elaboration.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_issue_ctrl: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_capture;

    // The transfer happens on the edge where both sides agree. in_ready is a
    // function of state and out_ready only, never of in_valid.
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == ST_SETTLE) && (r_cnt == '0);

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. Without that,
        // a state that does not assign a signal would infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                out_valid = 1'b1;
                // Passing out_ready straight through lets the consuming edge
                // also launch the next transaction.
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? ST_SETTLE : ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and settle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks. All registers then
        // update together at the edge, whatever order the blocks run in.
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Operand launch registers: they change only on acceptance, so the ALU
    // inputs stay quiet between transactions.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
        end else if (w_accept) begin
            alu_a      <= in_a;
            alu_b      <= in_b;
            alu_select <= in_op;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture registers: they hold the last result while out_valid is 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_op     <= '0;
        end else if (w_capture) begin
            out_result <= alu_result;
            out_carry  <= alu_carry;
            out_zero   <= (alu_result == '0);
            out_op     <= alu_select;
        end
    end

endmodule
